// File: rtl/mul_addtree_pkg.sv
// mul_addtree_pkg: shared constants and sizing helpers for the adder-tree multiplier.
package mul_addtree_pkg;
    localparam int MUL_ADDTREE_DEFAULT_WIDTH = 4;

    function automatic int tree_levels(input int width);
        return $clog2(width);
    endfunction

    function automatic int prod_w(input int width);
        return 2 * width;
    endfunction
endpackage

// File: rtl/mul_addtree_level.sv
// mul_addtree_level: one registered adder-tree level; pairwise sums of N W-bit operands into N/2 results.
module mul_addtree_level #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [N*W-1:0]     operands,
    output logic               out_valid,
    output logic [N/2*W-1:0]   sums
);
    logic [N/2*W-1:0] pair_sum;

    for (genvar k = 0; k < N / 2; k++) begin : g_pair
        assign pair_sum[k*W +: W] = operands[2*k*W +: W] + operands[(2*k+1)*W +: W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sums      <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) sums <= pair_sum;
        end
    end
endmodule

// File: rtl/mul_addtree.sv
// mul_addtree: pipelined unsigned WIDTH x WIDTH shift-and-add multiplier, one register bank per tree level.
// Define MUL_ADDTREE_INREG_EN to register the operands ahead of partial-product generation (+1 cycle).
module mul_addtree
    import mul_addtree_pkg::*;
#(
    parameter int WIDTH = MUL_ADDTREE_DEFAULT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         mul_a,
    input  logic [WIDTH-1:0]         mul_b,
    output logic                     out_valid,
    output logic [prod_w(WIDTH)-1:0] product
);
    localparam int LEVELS = tree_levels(WIDTH);
    localparam int PW     = prod_w(WIDTH);

    logic [WIDTH-1:0] op_a, op_b;
    logic             op_valid;

`ifdef MUL_ADDTREE_INREG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_valid <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
        end else begin
            op_valid <= in_valid;
            if (in_valid) begin
                op_a <= mul_a;
                op_b <= mul_b;
            end
        end
    end
`else
    assign op_valid = in_valid;
    assign op_a     = mul_a;
    assign op_b     = mul_b;
`endif

    logic [WIDTH*PW-1:0] pp;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pp
        assign pp[i*PW +: PW] = op_b[i] ? ({{(PW-WIDTH){1'b0}}, op_a} << i) : '0;
    end

    // Each level halves the operand count; level l consumes the sums of level l-1.
    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int N = WIDTH >> l;
        logic [N/2*PW-1:0] sums;
        logic              valid;
        if (l == 0) begin : g_first
            mul_addtree_level #(.N(N), .W(PW)) u_level (
                .clk      (clk),
                .rst_n    (rst_n),
                .in_valid (op_valid),
                .operands (pp),
                .out_valid(valid),
                .sums     (sums)
            );
        end else begin : g_next
            mul_addtree_level #(.N(N), .W(PW)) u_level (
                .clk      (clk),
                .rst_n    (rst_n),
                .in_valid (g_lvl[l-1].valid),
                .operands (g_lvl[l-1].sums),
                .out_valid(valid),
                .sums     (sums)
            );
        end
    end

    assign out_valid = g_lvl[LEVELS-1].valid;
    assign product   = g_lvl[LEVELS-1].sums;
endmodule

// File: tb/tb_mul_addtree.sv
// tb_mul_addtree: randomized self-checking bench for 4-bit and 8-bit mul_addtree against a delay-line product model.
module tb_mul_addtree;
`ifdef MUL_ADDTREE_INREG_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int LAT4 = 2 + EXTRA;
    localparam int LAT8 = 3 + EXTRA;

    typedef struct {
        bit v;
        int p;
    } ent_t;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        in_valid = 0;
    logic [3:0]  mul_a = 0, mul_b = 0;
    logic [7:0]  a8 = 0, b8 = 0;
    logic        out_valid, out_valid8;
    logic [7:0]  product;
    logic [15:0] product8;

    int   checks = 0, failures = 0;
    ent_t q4[$], q8[$];
    bit   ev4, ev8;
    int   ep4, ep8;

    mul_addtree #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mul_a(mul_a), .mul_b(mul_b),
        .out_valid(out_valid), .product(product)
    );

    mul_addtree #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mul_a(a8), .mul_b(b8),
        .out_valid(out_valid8), .product(product8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        check("valid4", int'(out_valid), int'(ev4));
        check("prod4", int'(product), ep4);
        check("valid8", int'(out_valid8), int'(ev8));
        check("prod8", int'(product8), ep8);
    endtask

    task automatic clear_model();
        q4.delete();
        q8.delete();
        ev4 = 0; ev8 = 0; ep4 = 0; ep8 = 0;
    endtask

    task automatic assert_reset();
        rst_n = 0;
        clear_model();
        #1;
        check_outputs();
    endtask

    // One clock: drive, let the edge happen, advance the delay-line model, then compare.
    task automatic cyc(input bit v, input int a, input int b);
        ent_t e;
        in_valid = v;
        mul_a = 4'(a);
        mul_b = 4'(b);
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        @(posedge clk);
        if (rst_n) begin
            q4.push_back('{v, a * b});
            q8.push_back('{v, int'(a8) * int'(b8)});
            ev4 = 0;
            ev8 = 0;
            if (q4.size() > LAT4 - 1) begin
                e = q4.pop_front();
                ev4 = e.v;
                if (e.v) ep4 = e.p;
            end
            if (q8.size() > LAT8 - 1) begin
                e = q8.pop_front();
                ev8 = e.v;
                if (e.v) ep8 = e.p;
            end
        end
        #1;
        check_outputs();
    endtask

    initial begin
        assert_reset();
        for (int i = 0; i < 3; i++) cyc(1, $urandom_range(15), $urandom_range(15));
        rst_n = 1;
        for (int i = 0; i < 3; i++) cyc(0, $urandom_range(15), $urandom_range(15));

        for (int i = 0; i < 10; i++) cyc(1, i, i);
        for (int i = 0; i < LAT8; i++) cyc(0, 0, 0);

        cyc(1, 15, 15);
        cyc(1, 15, 0);
        cyc(1, 0, 15);
        cyc(1, 15, 1);
        cyc(1, 8, 8);
        for (int i = 0; i < LAT8; i++) cyc(0, 0, 0);

        cyc(1, 7, 6);
        for (int i = 0; i < LAT4 + 2; i++) cyc(0, $urandom_range(15), $urandom_range(15));
        check("hold42", int'(product), 42);
        check("hold42_valid", int'(out_valid), 0);

        cyc(1, 9, 9);
        assert_reset();
        cyc(1, 3, 5);
        rst_n = 1;
        for (int i = 0; i < LAT8 + 1; i++) cyc(0, 0, 0);
        check("midrst_prod", int'(product), 0);

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++) cyc(1, a, b);
        for (int i = 0; i < 300; i++)
            cyc($urandom_range(3) != 0, $urandom_range(15), $urandom_range(15));
        for (int i = 0; i < LAT8 + 1; i++) cyc(0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mul_addtree.md
Name: mul_addtree

Overview:
- Pipelined unsigned WIDTH x WIDTH multiplier built as a shift-and-add partial-product adder tree.
- Default configuration is a 4x4 multiplier producing an 8-bit product.
- Datapath leaf block, used by arithmetic front-ends; streaming valid-in/valid-out with no backpressure.

Parameters:
- WIDTH, 4, operand width in bits; power of two, 2..16.

Ports:
- clk  input  1  system clock; all registers rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands on mul_a/mul_b are valid this cycle.
- mul_a  input  WIDTH  multiplicand, unsigned.
- mul_b  input  WIDTH  multiplier, unsigned.
- out_valid  output  1  product is valid this cycle.
- product  output  2*WIDTH  unsigned product mul_a*mul_b.

Behaviour:
- Partial products, combinational at the input: pp[i] = mul_b[i] ? (mul_a zero-extended to 2*WIDTH, shifted left by i) : 0, for i = 0..WIDTH-1.
- Adder tree with LEVELS = log2(WIDTH) levels of pairwise 2*WIDTH-bit additions. Level 1 is pp[0]+pp[1], pp[2]+pp[3], ...; the final level yields the product.
- For WIDTH=4 the tree is add01 = pp0+pp1, add23 = pp2+pp3, then product = add01+add23.
- All sums are 2*WIDTH bits wide and never overflow, since the maximum is (2^WIDTH-1)^2.
- One pipeline register bank sits after each tree level. Latency is LEVELS cycles (2 for WIDTH=4).
- Throughput is one operation per cycle. in_valid may be asserted every cycle.
- A valid bit shifts alongside the data. out_valid is the valid bit of the last stage.
- Each stage's data registers load only when that stage's incoming valid is 1. When out_valid=0, product holds the last valid result (0 after reset).
- No backpressure: results are not stalled. An unconsumed result is overwritten by the next one.
- Reset (asynchronous, rst_n=0): all valid bits and all data registers clear to 0, so out_valid=0 and product=0.
- Reset asserted mid-operation discards all in-flight results; no out_valid pulse follows for them.
- Release of reset is synchronous to clk. The first operand can be accepted on the first rising edge with rst_n=1.
- Edge cases:
  - mul_a=0 or mul_b=0 -> product 0.
  - mul_b=1 -> product = mul_a.
  - All-ones operands -> (2^WIDTH-1)^2, e.g. 225 for WIDTH=4.

Optional Feature:
- Macro MUL_ADDTREE_INREG_EN.
- When defined: mul_a, mul_b and in_valid are registered before partial-product generation. Latency becomes LEVELS+1 (3 for WIDTH=4). The input registers reset to 0 and load only when in_valid=1.
- When undefined: no input registers, and latency is LEVELS.
- Functional results are identical in both builds.

Decomposition:
- Package mul_addtree_pkg holds:
  - MUL_ADDTREE_DEFAULT_WIDTH = 4;
  - function tree_levels(width) returning log2(width);
  - localparam-style constant PROD_W(width) = 2*width.
- Sub-module mul_addtree_level: one registered tree level. It adds adjacent operand pairs from an N-entry vector into an N/2-entry vector and carries the valid bit. It has clk, rst_n, async reset, and a clock enable from the valid bit.
- The top instantiates LEVELS copies of mul_addtree_level via generate, plus the partial-product generator.

Test Plan:
- Reset: rst_n=0 with random inputs -> out_valid=0, product=0. Hold for 3 cycles after release with in_valid=0 -> outputs unchanged.
- Sweep: a=b=0..9 applied one per cycle with in_valid=1 -> products 0,1,4,9,16,25,36,49,64,81 appear 2 cycles later, back-to-back, with out_valid high.
- Corners: (15,15) -> 225; (15,0) -> 0; (0,15) -> 0; (15,1) -> 15; (8,8) -> 64. Each arrives after exactly 2 cycles.
- Bubbles/hold: (7,6) valid, then 3 cycles of in_valid=0 with changing operands -> one out_valid pulse, product=42, and product stays 42 afterwards.
- Mid-flight reset: issue (9,9) and (3,5), then pulse rst_n low before they emerge -> no out_valid, product=0.
- Exhaustive: all 256 operand pairs streamed continuously, for WIDTH=4 with and without MUL_ADDTREE_INREG_EN -> product equals a*b at latency 2 or 3 respectively. Repeat the random check for WIDTH=8 with latency 3.
